// File: rtl/eth_fcs_inserter.sv
`timescale 1ns/1ps
// crc: byte-wide reflected Ethernet CRC-32 (poly 0x04C11DB7, preset all ones, final inversion).
// Latency: the result is combinational on the tlast beat and includes that beat's byte.
// Backpressure: in_axis_tready follows out_axis_tready; the LFSR only advances on accepted beats.
// Ports: clk/sresetn (sync, active-low); in_axis_* byte stream; out_axis_* 32-bit CRC, valid on the tlast beat.
module crc (
    input  logic        clk,
    input  logic        sresetn,
    output logic        in_axis_tready,
    input  logic        in_axis_tvalid,
    input  logic        in_axis_tlast,
    input  logic [7:0]  in_axis_tdata,
    input  logic        out_axis_tready,
    output logic        out_axis_tvalid,
    output logic [31:0] out_axis_tdata
);
    logic [31:0] lfsr_q;
    logic [31:0] lfsr_nxt;
    logic        beat;

    // Bit-serial update, LSB of the byte first (Ethernet bit order).
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ d[k];
            r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0000_0000);
        end
        return r;
    endfunction

    assign lfsr_nxt        = crc_byte(lfsr_q, in_axis_tdata);
    assign in_axis_tready  = out_axis_tready;
    assign beat            = in_axis_tvalid & in_axis_tready;
    assign out_axis_tvalid = beat & in_axis_tlast;
    assign out_axis_tdata  = ~lfsr_nxt;

    // Re-preset after the last byte so the next frame starts clean.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            lfsr_q <= '1;
        end else if (beat) begin
            lfsr_q <= in_axis_tlast ? 32'hFFFF_FFFF : lfsr_nxt;
        end
    end
endmodule

// eth_fcs_inserter: passes payload bytes through, zero-pads short frames, appends the 4-byte FCS LSB first.
// Latency: zero cycles in PASS (combinational pass-through); pad and FCS bytes are generated internally.
// Backpressure: upstream tready mirrors downstream tready in PASS, held low in PAD/FCS; stalls never advance the CRC.
// Ports: clk, sreset (sync, active-high); in_axis_* payload in; out_axis_* payload+pad+FCS out; busy = PAD or FCS.
module eth_fcs_inserter #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int CNT_WIDTH       = 16
) (
    input  logic       clk,
    input  logic       sreset,
    output logic       in_axis_tready,
    input  logic       in_axis_tvalid,
    input  logic       in_axis_tlast,
    input  logic [7:0] in_axis_tdata,
    input  logic       out_axis_tready,
    output logic       out_axis_tvalid,
    output logic       out_axis_tlast,
    output logic [7:0] out_axis_tdata,
    output logic       busy
);
    typedef enum logic [1:0] {ST_PASS, ST_PAD, ST_FCS} state_t;

    localparam logic [CNT_WIDTH:0] MIN_C = (CNT_WIDTH+1)'(MIN_FRAME_BYTES);
    localparam logic [CNT_WIDTH:0] ONE_C = (CNT_WIDTH+1)'(1);

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [1:0]           idx_q;
    logic [31:0]          fcs_q;

    logic [CNT_WIDTH:0]   cnt_inc;
    logic [CNT_WIDTH-1:0] cnt_sat;
    logic                 reach_min;
    logic                 out_beat;
    logic                 crc_vld;
    logic                 crc_last;
    logic                 crc_rdy;
    logic                 crc_res_vld;
    logic [31:0]          crc_res;

    // Extra bit so the compare against MIN_FRAME_BYTES never wraps.
    assign cnt_inc   = {1'b0, cnt_q} + ONE_C;
    assign reach_min = (cnt_inc >= MIN_C);
    assign cnt_sat   = reach_min ? MIN_C[CNT_WIDTH-1:0] : cnt_inc[CNT_WIDTH-1:0];

    always_comb begin
        in_axis_tready  = 1'b0;
        out_axis_tvalid = 1'b0;
        out_axis_tlast  = 1'b0;
        out_axis_tdata  = 8'h00;
        busy            = 1'b0;
        if (!sreset) begin
            case (state_q)
                ST_PASS: begin
                    in_axis_tready  = out_axis_tready & crc_rdy;
                    out_axis_tvalid = in_axis_tvalid;
                    out_axis_tdata  = in_axis_tdata;
                end
                ST_PAD: begin
                    out_axis_tvalid = 1'b1;
                    busy            = 1'b1;
                end
                ST_FCS: begin
                    out_axis_tvalid = 1'b1;
                    out_axis_tdata  = fcs_q[{idx_q, 3'b000} +: 8];
                    out_axis_tlast  = (idx_q == 2'd3);
                    busy            = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_beat = out_axis_tvalid & out_axis_tready;
    assign crc_vld  = out_beat & (state_q != ST_FCS);
    // Last CRC byte: payload tlast once the frame is long enough, or the pad byte that reaches the minimum.
    assign crc_last = (state_q == ST_PASS) ? (in_axis_tlast & reach_min) : reach_min;

    crc u_crc (
        .clk             (clk),
        .sresetn         (~sreset),
        .in_axis_tready  (crc_rdy),
        .in_axis_tvalid  (crc_vld),
        .in_axis_tlast   (crc_last),
        .in_axis_tdata   (out_axis_tdata),
        .out_axis_tready (1'b1),
        .out_axis_tvalid (crc_res_vld),
        .out_axis_tdata  (crc_res)
    );

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q <= ST_PASS;
            cnt_q   <= '0;
            idx_q   <= '0;
            fcs_q   <= '0;
        end else begin
            if (crc_res_vld) begin
                fcs_q <= crc_res;
            end
            case (state_q)
                ST_PASS: begin
                    if (out_beat) begin
                        cnt_q <= cnt_sat;
                        if (in_axis_tlast) begin
                            idx_q   <= 2'd0;
                            state_q <= reach_min ? ST_FCS : ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    if (out_beat) begin
                        cnt_q <= cnt_sat;
                        if (reach_min) begin
                            idx_q   <= 2'd0;
                            state_q <= ST_FCS;
                        end
                    end
                end
                ST_FCS: begin
                    if (out_beat) begin
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= ST_PASS;
                            cnt_q   <= '0;
                        end
                    end
                end
                default: state_q <= ST_PASS;
            endcase
        end
    end
endmodule
